btn_conditioner: RTL and testbench

Parametrised multi-channel push-button front end for the debug and game-control path. For each of `N_BTN` raw board buttons it provides:
- two-flop synchronisation;
- stable-count debouncing;
- registered press/release pulses;
- long-press detection with optional auto-repeat;
- a per-channel press counter that wraps or saturates and can be cleared.

Its counter outputs feed the on-screen debug sequence display. Its level and pulse outputs feed the character controller.

---
 rtl/btn_cond_pkg.sv | 25 ++
 rtl/btn_channel.sv | 107 ++++++++++
 rtl/btn_conditioner.sv | 47 ++++
 tb/tb_btn_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared constants and sizing helpers for the button conditioner
package btn_cond_pkg;

    localparam int BTN_DB_CYCLES     = 500000;
    localparam int BTN_HOLD_CYCLES   = 50000000;
    localparam int BTN_REPEAT_CYCLES = 10000000;
    localparam int BTN_CNT_WIDTH     = 16;

    function automatic int clog2(input int value);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < value) begin
            p = p * 2;
            r++;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: sync, debounce, edge pulses, hold/repeat, press counter
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES     = BTN_DB_CYCLES,
    parameter int HOLD_CYCLES   = BTN_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter int CNT_WIDTH     = BTN_CNT_WIDTH,
    parameter bit REPEAT_EN     = 1'b1,
    parameter bit SATURATE      = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 btn_raw,
    input  logic                 cnt_clr,
    output logic                 btn_level,
    output logic                 btn_press,
    output logic                 btn_release,
    output logic                 btn_long,
    output logic                 btn_repeat,
    output logic [CNT_WIDTH-1:0] press_cnt
);

    localparam int DB_W   = clog2(DB_CYCLES + 1);
    localparam int HOLD_W = clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic              s1;
    logic              s2;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              db_done;
    logic              rise;
    logic              fall;
    logic              hold_hit;
    logic              cnt_inc;

    // hold_cnt doubles as the repeat-phase timer once btn_long is set
    always_comb begin
        db_done  = (s2 != btn_level) && (db_cnt == DB_LAST);
        rise     = db_done && s2;
        fall     = db_done && !s2;
        hold_hit = btn_level && !fall &&
                   (hold_cnt == (btn_long ? REP_LAST : HOLD_LAST));
        cnt_inc  = (btn_press || btn_repeat) && !(SATURATE && (&press_cnt));
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            btn_press   <= rise;
            btn_release <= fall;
            if (s2 != btn_level) begin
                if (db_done) begin
                    btn_level <= s2;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // the release edge suppresses any repeat that would land on it
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hold_cnt   <= '0;
            btn_long   <= 1'b0;
            btn_repeat <= 1'b0;
        end else if (!btn_level || fall) begin
            hold_cnt   <= '0;
            btn_long   <= 1'b0;
            btn_repeat <= 1'b0;
        end else if (hold_hit) begin
            hold_cnt   <= '0;
            btn_long   <= 1'b1;
            btn_repeat <= REPEAT_EN;
        end else begin
            hold_cnt   <= hold_cnt + HOLD_W'(1);
            btn_repeat <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            press_cnt <= '0;
        end else if (cnt_clr) begin
            press_cnt <= '0;
        end else if (cnt_inc) begin
            press_cnt <= press_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent button channels with packed outputs
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int               N_BTN         = 3,
    parameter int               DB_CYCLES     = BTN_DB_CYCLES,
    parameter int               HOLD_CYCLES   = BTN_HOLD_CYCLES,
    parameter int               REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter logic [N_BTN-1:0] REPEAT_EN     = {N_BTN{1'b1}},
    parameter int               CNT_WIDTH     = BTN_CNT_WIDTH,
    parameter bit               SATURATE      = 1'b0
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [N_BTN-1:0]             btn_raw,
    input  logic [N_BTN-1:0]             cnt_clr,
    output logic [N_BTN-1:0]             btn_level,
    output logic [N_BTN-1:0]             btn_press,
    output logic [N_BTN-1:0]             btn_release,
    output logic [N_BTN-1:0]             btn_long,
    output logic [N_BTN-1:0]             btn_repeat,
    output logic [N_BTN*CNT_WIDTH-1:0]   press_cnt
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_WIDTH     (CNT_WIDTH),
            .REPEAT_EN     (REPEAT_EN[i]),
            .SATURATE      (SATURATE)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .btn_raw     (btn_raw[i]),
            .cnt_clr     (cnt_clr[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i]),
            .btn_repeat  (btn_repeat[i]),
            .press_cnt   (press_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed bench for btn_conditioner (wrap/repeat and saturate/no-repeat builds)
module tb_btn_conditioner;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [2:0]  btn_raw;
    logic [2:0]  cnt_clr;

    logic [2:0]  level_a, press_a, release_a, long_a, repeat_a;
    logic [11:0] cnt_a;
    logic [2:0]  level_b, press_b, release_b, long_b, repeat_b;
    logic [11:0] cnt_b;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    btn_conditioner #(
        .N_BTN(3), .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
        .REPEAT_EN(3'b111), .CNT_WIDTH(4), .SATURATE(1'b0)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .btn_raw(btn_raw), .cnt_clr(cnt_clr),
        .btn_level(level_a), .btn_press(press_a), .btn_release(release_a),
        .btn_long(long_a), .btn_repeat(repeat_a), .press_cnt(cnt_a)
    );

    btn_conditioner #(
        .N_BTN(3), .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
        .REPEAT_EN(3'b110), .CNT_WIDTH(4), .SATURATE(1'b1)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .btn_raw(btn_raw), .cnt_clr(cnt_clr),
        .btn_level(level_b), .btn_press(press_b), .btn_release(release_b),
        .btn_long(long_b), .btn_repeat(repeat_b), .press_cnt(cnt_b)
    );

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        btn_raw   = 3'b000;
        cnt_clr   = 3'b000;
        step(3);
        check("rst_level", {29'd0, level_a}, 32'h0);
        check("rst_cnt_a", {20'd0, cnt_a}, 32'h0);
        check("rst_long_b", {29'd0, long_b}, 32'h0);
        sys_rst_n = 1'b1;
        step(2);

        // clean press on ch0
        btn_raw = 3'b001;
        step(5);
        check("t1_level_early", {29'd0, level_a}, 32'h0);
        step(1);
        check("t1_level", {29'd0, level_a}, 32'h1);
        check("t1_press", {29'd0, press_a}, 32'h1);
        check("t1_cnt_lag", {20'd0, cnt_a}, 32'h000);
        step(1);
        check("t1_press_off", {29'd0, press_a}, 32'h0);
        check("t1_cnt_a", {20'd0, cnt_a}, 32'h001);
        btn_raw = 3'b000;
        step(5);
        check("t1_rel_early", {29'd0, release_a}, 32'h0);
        step(1);
        check("t1_release", {29'd0, release_a}, 32'h1);
        check("t1_level_low", {29'd0, level_a}, 32'h0);
        step(1);
        check("t1_release_off", {29'd0, release_a}, 32'h0);

        // glitch of 3 cycles on ch1, then a 4-cycle pulse that qualifies
        btn_raw = 3'b010;
        step(3);
        btn_raw = 3'b000;
        step(10);
        check("t2_glitch_level", {29'd0, level_a}, 32'h0);
        check("t2_glitch_cnt", {20'd0, cnt_a}, 32'h001);
        btn_raw = 3'b010;
        step(4);
        btn_raw = 3'b000;
        step(2);
        check("t2_press", {29'd0, press_a}, 32'h2);
        check("t2_level", {29'd0, level_a}, 32'h2);
        step(4);
        check("t2_release", {29'd0, release_a}, 32'h2);
        step(1);
        check("t2_cnt_a", {20'd0, cnt_a}, 32'h011);
        check("t2_cnt_b", {20'd0, cnt_b}, 32'h011);

        // long press and auto-repeat on ch0
        btn_raw = 3'b001;
        step(6);
        check("t3_press", {29'd0, press_a}, 32'h1);
        step(19);
        check("t3_long_early", {29'd0, long_a}, 32'h0);
        step(1);
        check("t3_long_a", {29'd0, long_a}, 32'h1);
        check("t3_rep_a", {29'd0, repeat_a}, 32'h1);
        check("t3_long_b", {29'd0, long_b}, 32'h1);
        check("t3_rep_b", {29'd0, repeat_b}, 32'h0);
        step(1);
        check("t3_rep_off", {29'd0, repeat_a}, 32'h0);
        check("t3_cnt_mid", {20'd0, cnt_a}, 32'h013);
        step(7);
        check("t3_rep28", {29'd0, repeat_a}, 32'h1);
        step(8);
        check("t3_rep36", {29'd0, repeat_a}, 32'h1);
        step(2);
        btn_raw = 3'b000;
        step(5);
        check("t3_long_held", {29'd0, long_a}, 32'h1);
        check("t3_rel_early", {29'd0, release_a}, 32'h0);
        step(1);
        check("t3_long_clr", {29'd0, long_a}, 32'h0);
        check("t3_release", {29'd0, release_a}, 32'h1);
        check("t3_no_rep_rel", {29'd0, repeat_a}, 32'h0);
        step(1);
        check("t3_cnt_a", {20'd0, cnt_a}, 32'h015);
        check("t3_cnt_b", {20'd0, cnt_b}, 32'h012);

        // 17 presses on ch2: wrap vs saturate
        for (int n = 0; n < 17; n++) begin
            btn_raw = 3'b100;
            step(6);
            btn_raw = 3'b000;
            step(6);
        end
        check("t4_wrap", {20'd0, cnt_a}, 32'h115);
        check("t4_sat", {20'd0, cnt_b}, 32'hF12);
        btn_raw = 3'b100;
        step(6);
        cnt_clr = 3'b100;
        step(1);
        cnt_clr = 3'b000;
        check("t4_clr_a", {20'd0, cnt_a}, 32'h015);
        check("t4_clr_b", {20'd0, cnt_b}, 32'h012);
        btn_raw = 3'b000;
        step(6);

        // reset during long press with ch0 still held
        btn_raw = 3'b001;
        step(26);
        check("t5_long", {29'd0, long_a}, 32'h1);
        sys_rst_n = 1'b0;
        step(1);
        check("t5_rst_level", {29'd0, level_a}, 32'h0);
        check("t5_rst_long", {29'd0, long_a}, 32'h0);
        check("t5_rst_cnt", {20'd0, cnt_a}, 32'h0);
        sys_rst_n = 1'b1;
        step(1);
        check("t5_no_release", {29'd0, release_a}, 32'h0);
        step(4);
        check("t5_level_early", {29'd0, level_a}, 32'h0);
        step(1);
        check("t5_press", {29'd0, press_a}, 32'h1);
        btn_raw = 3'b000;
        step(6);
        check("t5_cnt", {20'd0, cnt_a}, 32'h001);

        // simultaneous presses on every channel
        btn_raw = 3'b111;
        step(5);
        check("t6_level_early", {29'd0, level_a}, 32'h0);
        step(1);
        check("t6_press_a", {29'd0, press_a}, 32'h7);
        check("t6_press_b", {29'd0, press_b}, 32'h7);
        btn_raw = 3'b000;
        step(1);
        check("t6_cnt_a", {20'd0, cnt_a}, 32'h112);
        check("t6_cnt_b", {20'd0, cnt_b}, 32'h112);
        step(5);
        check("t6_release", {29'd0, release_a}, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
